// File: rtl/demux_key_buf.sv
// Key-addressed demultiplexer with a one-entry buffer per output lane.
// Each lane has its own valid/ready handshake; keys with no lane are dropped and counted.
module demux_key_buf #(
  parameter int NR_OUT   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  parameter int CNT_LEN  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [KEY_LEN-1:0]         key,
  input  logic [DATA_LEN-1:0]        din,
  output logic [NR_OUT*DATA_LEN-1:0] out_data,
  output logic [NR_OUT-1:0]          out_valid,
  input  logic [NR_OUT-1:0]          out_ready,
  output logic [CNT_LEN-1:0]         miss_cnt
);

  localparam logic [KEY_LEN:0] LANES = (KEY_LEN+1)'(NR_OUT);
  localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

  logic              hit;
  logic              accept;
  logic [NR_OUT-1:0] sel;
  logic [NR_OUT-1:0] load;
  logic [NR_OUT-1:0] valid_d;

  // Extra key bit so NR_OUT == 2**KEY_LEN still compares correctly
  assign hit = {1'b0, key} < LANES;

  always_comb begin
    sel = '0;
    for (int n = 0; n < NR_OUT; n++) begin
      sel[n] = hit && (key == KEY_LEN'(n));
    end
  end

  // Output logic: a lane can take a word when empty or draining now
  always_comb begin
    in_ready = 1'b1;
    if (hit) begin
      in_ready = |(sel & (~out_valid | out_ready));
    end
  end

  // Next-state logic for the per-lane EMPTY/FULL flags
  always_comb begin
    accept  = in_valid && in_ready;
    load    = accept ? sel : '0;
    valid_d = load | (out_valid & ~out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
    end else begin
      out_valid <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else begin
      for (int n = 0; n < NR_OUT; n++) begin
        if (load[n]) begin
          out_data[n*DATA_LEN +: DATA_LEN] <= din;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (accept && !hit && miss_cnt != CNT_MAX) begin
      miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_key_buf.sv
// Bench for demux_key_buf: directed vector table, miss/reset sequences,
// and randomized traffic against per-lane reference queues.
module tb_demux_key_buf;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_iv, a_rdy;
  logic [1:0] a_key, a_din;
  logic [7:0] a_od;
  logic [3:0] a_ov, a_or;
  logic [7:0] a_miss;

  logic       b_iv, b_rdy, c_rdy;
  logic [1:0] b_key, b_din;
  logic [5:0] b_od, c_od;
  logic [2:0] b_ov, c_ov, b_or;
  logic [7:0] b_miss;
  logic [1:0] c_miss;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  demux_key_buf #(.NR_OUT(4), .KEY_LEN(2), .DATA_LEN(2), .CNT_LEN(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_rdy),
    .key(a_key), .din(a_din), .out_data(a_od), .out_valid(a_ov),
    .out_ready(a_or), .miss_cnt(a_miss)
  );

  demux_key_buf #(.NR_OUT(3), .KEY_LEN(2), .DATA_LEN(2), .CNT_LEN(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_rdy),
    .key(b_key), .din(b_din), .out_data(b_od), .out_valid(b_ov),
    .out_ready(b_or), .miss_cnt(b_miss)
  );

  demux_key_buf #(.NR_OUT(3), .KEY_LEN(2), .DATA_LEN(2), .CNT_LEN(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(c_rdy),
    .key(b_key), .din(b_din), .out_data(c_od), .out_valid(c_ov),
    .out_ready(b_or), .miss_cnt(c_miss)
  );

  typedef struct {
    logic       iv;
    logic [1:0] k;
    logic [1:0] d;
    logic [3:0] ordy;
    logic       rdy;
    logic [3:0] ov;
    logic [7:0] od;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_iv = 1'b0; a_key = '0; a_din = '0; a_or = '0;
    b_iv = 1'b0; b_key = '0; b_din = '0; b_or = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_random(input bit useb, input int cycles);
    logic [1:0] q[4][$];
    int         nr;
    int         miss;
    logic       iv, rdy, erdy;
    logic [1:0] k, d;
    logic [3:0] ordy, ov;
    logic [7:0] od;
    logic [7:0] mc;
    nr = useb ? 3 : 4;
    miss = 0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      iv   = $urandom_range(0, 9) < 7;
      k    = 2'($urandom_range(0, 3));
      d    = 2'($urandom_range(0, 3));
      ordy = 4'($urandom);
      if (useb) begin
        b_iv = iv; b_key = k; b_din = d; b_or = ordy[2:0];
      end else begin
        a_iv = iv; a_key = k; a_din = d; a_or = ordy;
      end
      @(negedge clk);
      rdy = useb ? b_rdy : a_rdy;
      ov  = useb ? {1'b0, b_ov} : a_ov;
      od  = useb ? {2'b00, b_od} : a_od;
      mc  = useb ? b_miss : a_miss;
      erdy = (int'(k) >= nr) || (q[k].size() == 0) || ordy[k];
      chk("rand_in_ready", 32'(rdy), 32'(erdy));
      for (int n = 0; n < nr; n++) begin
        chk("rand_out_valid", 32'(ov[n]), 32'(q[n].size() != 0));
        if (q[n].size() != 0) begin
          chk("rand_lane_data", 32'(od[2*n +: 2]), 32'(q[n][0]));
        end
      end
      chk("rand_miss_cnt", 32'(mc), 32'(miss));
      for (int n = 0; n < nr; n++) begin
        if (ordy[n] && q[n].size() != 0) void'(q[n].pop_front());
      end
      if (iv && erdy) begin
        if (int'(k) < nr) q[k].push_back(d);
        else if (miss < 255) miss++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    // Directed table: rdy is sampled before the edge, ov/od after it
    tbl[0]  = '{1'b1, 2'd2, 2'd3, 4'b0000, 1'b1, 4'b0100, 8'h30};
    tbl[1]  = '{1'b0, 2'd2, 2'd0, 4'b0000, 1'b0, 4'b0100, 8'h30};
    tbl[2]  = '{1'b0, 2'd0, 2'd0, 4'b0000, 1'b1, 4'b0100, 8'h30};
    tbl[3]  = '{1'b0, 2'd1, 2'd0, 4'b0000, 1'b1, 4'b0100, 8'h30};
    tbl[4]  = '{1'b0, 2'd3, 2'd0, 4'b0000, 1'b1, 4'b0100, 8'h30};
    tbl[5]  = '{1'b1, 2'd2, 2'd1, 4'b0100, 1'b1, 4'b0100, 8'h10};
    tbl[6]  = '{1'b1, 2'd1, 2'd2, 4'b0000, 1'b1, 4'b0110, 8'h18};
    for (int i = 7; i < 12; i++) begin
      tbl[i] = '{1'b1, 2'd1, 2'd0, 4'b0000, 1'b0, 4'b0110, 8'h18};
    end
    tbl[12] = '{1'b1, 2'd1, 2'd0, 4'b0010, 1'b1, 4'b0110, 8'h10};
    tbl[13] = '{1'b0, 2'd1, 2'd0, 4'b1111, 1'b1, 4'b0000, 8'h10};

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(a_ov), 32'h0);
    chk("reset_out_data", 32'(a_od), 32'h0);
    chk("reset_miss_cnt", 32'(a_miss), 32'h0);
    chk("reset_miss_cnt_b", 32'(b_miss), 32'h0);
    tick();

    for (int i = 0; i < 14; i++) begin
      a_iv = tbl[i].iv; a_key = tbl[i].k;
      a_din = tbl[i].d; a_or = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(a_rdy), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(a_ov), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_out_data", i), 32'(a_od), 32'(tbl[i].od));
    end
    idle();

    // Misses on the three-lane instances; CNT_LEN=2 copy saturates at 3
    for (int i = 1; i <= 6; i++) begin
      b_iv = 1'b1; b_key = 2'd3; b_din = 2'(i);
      @(negedge clk);
      chk("miss_in_ready", 32'(b_rdy), 32'h1);
      tick();
      chk("miss_cnt8", 32'(b_miss), 32'(i));
      chk("miss_cnt2_sat", 32'(c_miss), 32'(i > 3 ? 3 : i));
      chk("miss_out_valid", 32'(b_ov), 32'h0);
    end
    idle();
    chk("nomiss_full_keyspace", 32'(a_miss), 32'h0);

    // Fill all lanes, then reset alongside handshakes on every input
    for (int n = 0; n < 4; n++) begin
      a_iv = 1'b1; a_key = 2'(n); a_din = 2'(3 - n); a_or = '0;
      tick();
    end
    chk("fill_out_valid", 32'(a_ov), 32'hf);
    chk("fill_out_data", 32'(a_od), 32'h1b);
    rst = 1'b1;
    a_iv = 1'b1; a_key = 2'd0; a_din = 2'd2; a_or = 4'b1111;
    b_iv = 1'b1; b_key = 2'd3; b_or = 3'b111;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_ovr_out_valid", 32'(a_ov), 32'h0);
    chk("rst_ovr_out_data", 32'(a_od), 32'h0);
    chk("rst_ovr_miss_a", 32'(a_miss), 32'h0);
    chk("rst_ovr_miss_b", 32'(b_miss), 32'h0);
    chk("rst_ovr_miss_c", 32'(c_miss), 32'h0);

    run_random(1'b0, 400);
    run_random(1'b1, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/demux_key_buf.md
Name: demux_key_buf

Overview:
- Inverse of the team's key-selected mux: accepts one DATA_LEN-bit word plus a KEY_LEN-bit key per handshake and routes the word to the output lane whose index equals the key.
- Each lane holds its word in a one-entry buffer with its own valid/ready handshake, so slow consumers stall only their own traffic.
- Keys with no lane are accepted, discarded and counted.
- Sits between a key-tagged producer (switch/key decode logic) and per-lane display or register sinks.

Parameters:
- NR_OUT, 4, number of output lanes; must satisfy 1 <= NR_OUT <= 2**KEY_LEN.
- KEY_LEN, 2, key width in bits.
- DATA_LEN, 2, data word width in bits.
- CNT_LEN, 8, width of the miss counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word accepted this cycle when in_valid && in_ready.
- key  input  KEY_LEN  destination lane index.
- din  input  DATA_LEN  data word.
- out_data  output  NR_OUT*DATA_LEN  packed lane data; lane n at [DATA_LEN*(n+1)-1 : DATA_LEN*n].
- out_valid  output  NR_OUT  lane n holds a word.
- out_ready  input  NR_OUT  consumer n takes its word when out_valid[n] && out_ready[n].
- miss_cnt  output  CNT_LEN  count of accepted words with key >= NR_OUT.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - out_valid = 0, out_data = 0, miss_cnt = 0.
  - Reset overrides every handshake in the same cycle; no transfer completes on a cycle where rst = 1.
- Lane state machine, per lane n:
  - EMPTY -> FULL on accept with key == n. Data is loaded on that edge.
  - FULL -> EMPTY on consume (out_ready[n]) with no new accept for lane n.
  - FULL -> FULL on consume plus a simultaneous accept for lane n. New data is loaded and out_valid[n] stays 1, giving a pass-through at full throughput.
  - FULL with no consume: data and valid are held stable. Data must not change while out_valid[n] = 1 and out_ready[n] = 0.
- in_ready is combinational:
  - Hit (key < NR_OUT): in_ready = !out_valid[key] || out_ready[key].
  - Miss (key >= NR_OUT): in_ready = 1.
  - in_ready may be asserted regardless of in_valid.
  - There is no combinational path from din to any output.
- Latency: an accepted word appears on its lane's out_data/out_valid the cycle after acceptance (1-cycle latency).
- Only the keyed lane is affected by an accept; all other lanes are untouched.
- Miss handling:
  - An accepted miss word is dropped and miss_cnt increments by 1.
  - miss_cnt saturates at 2**CNT_LEN-1 and does not wrap.
- Lanes consume independently. Any subset of lanes may drain in the same cycle as an accept to a different lane.
- When in_valid = 0, key and din are don't-care and no state changes except consumes.
- out_ready for an EMPTY lane is ignored.
- When NR_OUT == 2**KEY_LEN, misses are impossible and miss_cnt stays 0.

Test Plan:
- Reset, then send key=2, din=2'b11 with out_ready=0 -> next cycle out_valid=4'b0100, lane2 data=2'b11; in_ready for key=2 drops to 0 while the other keys show in_ready=1.
- Lane2 FULL; present key=2, din=2'b01 with out_ready[2]=1 -> accepted same cycle, next cycle lane2=2'b01 and out_valid[2]=1 (pass-through).
- Lane1 stalled (out_ready[1]=0) with data 2'b10; hold key=1, din=2'b00 for 5 cycles -> in_ready=0 throughout, lane1 data stays 2'b10; raise out_ready[1] -> new word accepted that cycle.
- NR_OUT=3: send key=3 six times -> in_ready=1 each time, miss_cnt=6, out_valid unchanged. With CNT_LEN=2, 5 misses -> miss_cnt=3 (saturated).
- Fill all four lanes, then assert rst for one cycle together with in_valid and out_ready=4'b1111 -> out_valid=0, out_data=0, miss_cnt=0 after the edge; no transfer is counted.
- Random traffic with random out_ready, checked against a per-lane reference queue -> no word lost, duplicated or reordered per lane; the miss count matches.
